// File: rtl/fetch_stage.sv
// Instruction-fetch control: issues imem requests, drives the PC write port and
// owns the IF/ID latch, handling stalls, redirects with a fetch in flight, and halt.
module fetch_stage #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pco,
    output logic        pc_wen,
    output logic [31:0] pci,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_reg, state_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic [31:0] ifid_npc_reg, ifid_npc_next;
    logic [31:0] buf_instr_reg, buf_instr_next;
    logic [31:0] buf_npc_reg, buf_npc_next;
    logic [31:0] drop_addr_reg, drop_addr_next;
    logic [31:0] seq_pc;

    assign seq_pc = pco + STEP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= FETCH;
            ifid_valid_reg <= 1'b0;
            ifid_instr_reg <= '0;
            ifid_npc_reg   <= '0;
            buf_instr_reg  <= '0;
            buf_npc_reg    <= '0;
            drop_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_npc_reg   <= ifid_npc_next;
            buf_instr_reg  <= buf_instr_next;
            buf_npc_reg    <= buf_npc_next;
            drop_addr_reg  <= drop_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_npc_next   = ifid_npc_reg;
        buf_instr_next  = buf_instr_reg;
        buf_npc_next    = buf_npc_reg;
        drop_addr_next  = drop_addr_reg;
        iREN            = 1'b0;
        iaddr           = pco;
        pc_wen          = 1'b0;
        pci             = seq_pc;

        unique case (state_reg)
            FETCH: begin
                iREN = 1'b1;
                if (flush) begin
                    pc_wen          = 1'b1;
                    pci             = branch_target;
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = '0;
                    ifid_npc_next   = '0;
                    // A miss is still outstanding at pco; finish it and throw it away.
                    if (!ihit) begin
                        drop_addr_next = pco;
                        state_next     = DROP;
                    end
                end else if (halt) begin
                    iREN            = 1'b0;
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = '0;
                    ifid_npc_next   = '0;
                    state_next      = HALTED;
                end else if (ihit) begin
                    pc_wen = 1'b1;
                    if (stall) begin
                        buf_instr_next = iload;
                        buf_npc_next   = seq_pc;
                        state_next     = HOLD;
                    end else begin
                        ifid_valid_next = 1'b1;
                        ifid_instr_next = iload;
                        ifid_npc_next   = seq_pc;
                    end
                end else if (!stall) begin
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = '0;
                    ifid_npc_next   = '0;
                end
            end
            HOLD: begin
                if (flush || halt) begin
                    pc_wen          = flush;
                    pci             = flush ? branch_target : seq_pc;
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = '0;
                    ifid_npc_next   = '0;
                    buf_instr_next  = '0;
                    buf_npc_next    = '0;
                    state_next      = flush ? FETCH : HALTED;
                end else if (!stall) begin
                    ifid_valid_next = 1'b1;
                    ifid_instr_next = buf_instr_reg;
                    ifid_npc_next   = buf_npc_reg;
                    state_next      = FETCH;
                end
            end
            DROP: begin
                iREN            = 1'b1;
                iaddr           = drop_addr_reg;
                ifid_valid_next = 1'b0;
                ifid_instr_next = '0;
                ifid_npc_next   = '0;
                if (flush) begin
                    pc_wen = 1'b1;
                    pci    = branch_target;
                end
                if (ihit) begin
                    state_next = FETCH;
                end
            end
            HALTED: begin
                ifid_valid_next = 1'b0;
                ifid_instr_next = '0;
                ifid_npc_next   = '0;
            end
            default: state_next = FETCH;
        endcase
    end

    assign ifid_valid = ifid_valid_reg;
    assign ifid_instr = ifid_instr_reg;
    assign ifid_npc   = ifid_npc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each task drives one scenario and checks inline.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pco;
    logic        pc_wen;
    logic [31:0] pci;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        halt;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.PC_STEP(4)) dut (
        .CLK(CLK), .RST(RST), .pco(pco), .pc_wen(pc_wen), .pci(pci),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .stall(stall), .flush(flush), .branch_target(branch_target), .halt(halt),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b0; iload = '0; stall = 1'b0; flush = 1'b0;
        branch_target = '0; halt = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; pco = 32'h0; idle_inputs();
        tick(); tick();
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%08h exp=00000000", ifid_instr); end
        checks++; if (ifid_npc !== 32'h0) begin failures++; $display("FAIL reset_npc got=%08h exp=00000000", ifid_npc); end
        RST = 1'b0; settle();
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h0 || pc_wen !== 1'b0) begin failures++; $display("FAIL reset_fetch iREN=%0h iaddr=%08h pc_wen=%0h exp 1/00000000/0", iREN, iaddr, pc_wen); end
        $display("reset: iREN=%0h iaddr=%08h valid=%0h", iREN, iaddr, ifid_valid);
    endtask

    task automatic test_sequential();
        pco = 32'h0; ihit = 1'b1; iload = 32'h20010001; settle();
        checks++; if (iaddr !== 32'h0 || pc_wen !== 1'b1 || pci !== 32'h4) begin failures++; $display("FAIL seq0_comb iaddr=%08h pc_wen=%0h pci=%08h exp 00000000/1/00000004", iaddr, pc_wen, pci); end
        tick();
        pco = 32'h4; iload = 32'h20020002; settle();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h20010001 || ifid_npc !== 32'h4) begin failures++; $display("FAIL seq0_ifid v=%0h instr=%08h npc=%08h exp 1/20010001/00000004", ifid_valid, ifid_instr, ifid_npc); end
        checks++; if (pc_wen !== 1'b1 || pci !== 32'h8 || iaddr !== 32'h4) begin failures++; $display("FAIL seq1_comb pc_wen=%0h pci=%08h iaddr=%08h exp 1/00000008/00000004", pc_wen, pci, iaddr); end
        tick();
        pco = 32'h8; ihit = 1'b0; settle();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h20020002 || ifid_npc !== 32'h8) begin failures++; $display("FAIL seq1_ifid v=%0h instr=%08h npc=%08h exp 1/20020002/00000008", ifid_valid, ifid_instr, ifid_npc); end
        checks++; if (pc_wen !== 1'b0) begin failures++; $display("FAIL seq_miss_wen got=%0h exp=0", pc_wen); end
        tick();
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL seq_miss_bubble v=%0h instr=%08h exp 0/00000000", ifid_valid, ifid_instr); end
        $display("sequential: last ifid v=%0h instr=%08h", ifid_valid, ifid_instr);
    endtask

    task automatic test_stall_hold();
        int wen_count = 0;
        pco = 32'h30; ihit = 1'b1; iload = 32'hAAAA0001; stall = 1'b0; settle();
        tick();
        pco = 32'h40; iload = 32'h12340040; stall = 1'b1; settle();
        if (pc_wen === 1'b1) wen_count++;
        checks++; if (pci !== 32'h44 || iREN !== 1'b1) begin failures++; $display("FAIL stall_hit pci=%08h iREN=%0h exp 00000044/1", pci, iREN); end
        tick();
        pco = 32'h44; iload = 32'h55555555;
        for (int i = 0; i < 2; i++) begin
            settle();
            if (pc_wen === 1'b1) wen_count++;
            checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL hold_iren cyc=%0d got=%0h exp=0", i, iREN); end
            checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hAAAA0001 || ifid_npc !== 32'h34) begin failures++; $display("FAIL hold_ifid cyc=%0d v=%0h instr=%08h npc=%08h exp 1/AAAA0001/00000034", i, ifid_valid, ifid_instr, ifid_npc); end
            tick();
        end
        stall = 1'b0; ihit = 1'b0; settle();
        if (pc_wen === 1'b1) wen_count++;
        checks++; if (wen_count !== 1) begin failures++; $display("FAIL stall_wen_count got=%0d exp=1", wen_count); end
        tick();
        settle();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h12340040 || ifid_npc !== 32'h44) begin failures++; $display("FAIL hold_release v=%0h instr=%08h npc=%08h exp 1/12340040/00000044", ifid_valid, ifid_instr, ifid_npc); end
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin failures++; $display("FAIL hold_refetch iREN=%0h iaddr=%08h exp 1/00000044", iREN, iaddr); end
        tick();
        $display("stall_hold: released instr=12340040 wen_count=%0d", wen_count);
    endtask

    task automatic test_flush_miss();
        pco = 32'h10; ihit = 1'b0; flush = 1'b1; branch_target = 32'h100; settle();
        checks++; if (pc_wen !== 1'b1 || pci !== 32'h100 || iaddr !== 32'h10) begin failures++; $display("FAIL flush_miss_comb pc_wen=%0h pci=%08h iaddr=%08h exp 1/00000100/00000010", pc_wen, pci, iaddr); end
        tick();
        flush = 1'b0; pco = 32'h100;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (iREN !== 1'b1 || iaddr !== 32'h10 || pc_wen !== 1'b0) begin failures++; $display("FAIL drop_wait cyc=%0d iREN=%0h iaddr=%08h pc_wen=%0h exp 1/00000010/0", i, iREN, iaddr, pc_wen); end
            tick();
        end
        ihit = 1'b1; iload = 32'hDEADBEEF; settle();
        checks++; if (iaddr !== 32'h10) begin failures++; $display("FAIL drop_hit_addr got=%08h exp=00000010", iaddr); end
        tick();
        ihit = 1'b0; settle();
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL drop_discard v=%0h instr=%08h exp 0/00000000", ifid_valid, ifid_instr); end
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin failures++; $display("FAIL drop_resume iREN=%0h iaddr=%08h exp 1/00000100", iREN, iaddr); end
        $display("flush_miss: resumed at iaddr=%08h", iaddr);
    endtask

    task automatic test_flush_hit();
        pco = 32'h20; ihit = 1'b1; iload = 32'h11111111; flush = 1'b1; branch_target = 32'h80; settle();
        checks++; if (pc_wen !== 1'b1 || pci !== 32'h80) begin failures++; $display("FAIL flush_hit_comb pc_wen=%0h pci=%08h exp 1/00000080", pc_wen, pci); end
        tick();
        pco = 32'h80; ihit = 1'b0; flush = 1'b0; settle();
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL flush_hit_drop v=%0h instr=%08h exp 0/00000000", ifid_valid, ifid_instr); end
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h80) begin failures++; $display("FAIL flush_hit_next iREN=%0h iaddr=%08h exp 1/00000080", iREN, iaddr); end
        $display("flush_hit: next iaddr=%08h", iaddr);
    endtask

    task automatic test_flush_beats_halt();
        pco = 32'h50; ihit = 1'b1; iload = 32'h22222222; halt = 1'b1; flush = 1'b1; branch_target = 32'h200; settle();
        checks++; if (pc_wen !== 1'b1 || pci !== 32'h200 || iREN !== 1'b1) begin failures++; $display("FAIL flush_halt_comb pc_wen=%0h pci=%08h iREN=%0h exp 1/00000200/1", pc_wen, pci, iREN); end
        tick();
        pco = 32'h200; ihit = 1'b0; halt = 1'b0; flush = 1'b0; settle();
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h200) begin failures++; $display("FAIL flush_halt_next iREN=%0h iaddr=%08h exp 1/00000200", iREN, iaddr); end
        $display("flush_beats_halt: iaddr=%08h", iaddr);
    endtask

    task automatic test_wrap();
        pco = 32'hFFFFFFFC; ihit = 1'b1; iload = 32'h0BADF00D; settle();
        checks++; if (pci !== 32'h0 || pc_wen !== 1'b1) begin failures++; $display("FAIL wrap_pci pci=%08h pc_wen=%0h exp 00000000/1", pci, pc_wen); end
        tick();
        pco = 32'h0; ihit = 1'b0; settle();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h0BADF00D || ifid_npc !== 32'h0) begin failures++; $display("FAIL wrap_ifid v=%0h instr=%08h npc=%08h exp 1/0BADF00D/00000000", ifid_valid, ifid_instr, ifid_npc); end
        $display("wrap: npc=%08h", ifid_npc);
    endtask

    task automatic test_reset_in_drop();
        pco = 32'h60; ihit = 1'b0; flush = 1'b1; branch_target = 32'h300; settle();
        tick();
        flush = 1'b0; pco = 32'h300; settle();
        checks++; if (iaddr !== 32'h60) begin failures++; $display("FAIL rst_drop_pre iaddr=%08h exp=00000060", iaddr); end
        RST = 1'b1;
        tick();
        RST = 1'b0; settle();
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_drop_valid got=%0h exp=0", ifid_valid); end
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h300) begin failures++; $display("FAIL rst_drop_fetch iREN=%0h iaddr=%08h exp 1/00000300", iREN, iaddr); end
        $display("reset_in_drop: iaddr=%08h", iaddr);
    endtask

    task automatic test_halt();
        pco = 32'h6C; ihit = 1'b1; iload = 32'h33333333; settle();
        tick();
        checks++; if (ifid_valid !== 1'b1) begin failures++; $display("FAIL pre_halt_valid got=%0h exp=1", ifid_valid); end
        pco = 32'h70; iload = 32'h44444444; halt = 1'b1; settle();
        checks++; if (iREN !== 1'b0 || pc_wen !== 1'b0) begin failures++; $display("FAIL halt_comb iREN=%0h pc_wen=%0h exp 0/0", iREN, pc_wen); end
        tick();
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush = (i == 2); branch_target = 32'h400; settle();
            checks++; if (iREN !== 1'b0 || pc_wen !== 1'b0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL halted cyc=%0d iREN=%0h pc_wen=%0h v=%0h exp 0/0/0", i, iREN, pc_wen, ifid_valid); end
            tick();
        end
        flush = 1'b0;
        $display("halt: iREN=%0h pc_wen=%0h valid=%0h", iREN, pc_wen, ifid_valid);
    endtask

    initial begin
        RST = 1'b1; pco = '0; idle_inputs();
        test_reset();
        test_sequential();
        test_stall_hold();
        test_flush_miss();
        test_flush_hit();
        test_flush_beats_halt();
        test_wrap();
        test_reset_in_drop();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
